// File: rtl/wb_uart_report_seq.sv
// Wishbone-master report sequencer: converts a latched binary value to BCD by double dabble and
// prints it as ASCII decimal (plus optional CR/LF) through the UART peripheral registers.
module wb_uart_report_seq #(
  parameter int unsigned VALUE_W        = 32,
  parameter int unsigned NUM_DIGITS     = 10,
  parameter int unsigned SUPPRESS_ZEROS = 1,
  parameter int unsigned EOL_MODE       = 2,
  parameter logic [31:0] ADDR_TXDATA    = 32'h7,
  parameter logic [31:0] ADDR_TXCTRL    = 32'h3,
  parameter logic [31:0] ADDR_STATUS    = 32'h5,
  parameter int unsigned TX_DONE_BIT    = 5,
  parameter int unsigned TX_READY_BIT   = 4,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned ACK_TIMEOUT    = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               ovf_o,
  output logic [31:0]        addr_o,
  output logic [31:0]        dat_o,
  input  logic [31:0]        dat_i,
  output logic               we_o,
  output logic [3:0]         sel_o,
  output logic               cyc_o,
  output logic               stb_o,
  input  logic               ack_i,
  input  logic               err_i
);

  localparam int unsigned BcdW  = 4 * NUM_DIGITS;
  localparam int unsigned DigW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TmoW  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);
  localparam int unsigned ConvW = $clog2(VALUE_W + 1);

  typedef enum logic [3:0] {
    StIdle, StConv, StSkip, StWrData, StWrCtrl, StPollDone, StPollRdy, StClr, StGap, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [VALUE_W-1:0] val_q, val_d;
  logic [BcdW-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [ConvW-1:0]   conv_q, conv_d;
  logic [DigW-1:0]    dig_q, dig_d;
  logic               in_eol_q, in_eol_d, eol_q, eol_d;
  logic               stb_q, stb_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic               err_q, err_d, ovf_q, ovf_d;
  logic               ovf_bit, bus_st, tmo_hit, bus_abort, last_eol;
  logic [3:0]         cur_digit;
  logic [7:0]         cur_char;
  logic               unused_dat;

  assign unused_dat = ^dat_i;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q == DigW'(i)) cur_digit = bcd_q[4*i +: 4];
    end
  end

  assign cur_char  = !in_eol_q ? (8'h30 + {4'h0, cur_digit}) :
                     ((EOL_MODE == 2) && !eol_q) ? 8'h0D : 8'h0A;
  assign last_eol  = (EOL_MODE == 2) ? eol_q : 1'b1;
  assign bus_st    = (state_q == StWrData) || (state_q == StWrCtrl) || (state_q == StPollDone) ||
                     (state_q == StPollRdy) || (state_q == StClr);
  assign tmo_hit   = (tmo_q == TmoW'(ACK_TIMEOUT - 1));
  // An ack on the final allowed cycle still counts; err always wins over ack.
  assign bus_abort = stb_q && (err_i || (tmo_hit && !ack_i));

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    bcd_d    = bcd_q;
    conv_d   = conv_q;
    dig_d    = dig_q;
    in_eol_d = in_eol_q;
    eol_d    = eol_q;
    stb_d    = stb_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    ovf_bit  = 1'b0;

    if (bus_st) begin
      if (!stb_q) begin
        stb_d = 1'b1;
        tmo_d = '0;
      end else if (bus_abort) begin
        stb_d   = 1'b0;
        err_d   = 1'b1;
        state_d = StDone;
      end else if (ack_i) begin
        stb_d = 1'b0;
        case (state_q)
          StWrData:   state_d = StWrCtrl;
          StWrCtrl:   state_d = StPollDone;
          StPollDone: if (dat_i[TX_DONE_BIT]) state_d = StPollRdy;
          StPollRdy:  if (dat_i[TX_READY_BIT]) state_d = StClr;
          default: begin
            state_d = StGap;
            gap_d   = '0;
          end
        endcase
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          val_d    = value_i;
          bcd_d    = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          conv_d   = '0;
          dig_d    = DigW'(NUM_DIGITS - 1);
          in_eol_d = 1'b0;
          eol_d    = 1'b0;
          state_d  = StConv;
        end
      end
      StConv: begin
        {ovf_bit, bcd_d} = {bcd_adj, val_q[VALUE_W-1]};
        if (ovf_bit) ovf_d = 1'b1;
        val_d  = val_q << 1;
        conv_d = conv_q + 1'b1;
        if (conv_q == ConvW'(VALUE_W - 1)) state_d = StSkip;
      end
      StSkip: begin
        if ((SUPPRESS_ZEROS != 0) && (dig_q != '0) && (cur_digit == 4'h0)) begin
          dig_d = dig_q - 1'b1;
        end else begin
          state_d = StWrData;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StWrData;
          if (!in_eol_q) begin
            if (dig_q != '0) begin
              dig_d = dig_q - 1'b1;
            end else if (EOL_MODE == 0) begin
              state_d = StDone;
            end else begin
              in_eol_d = 1'b1;
              eol_d    = 1'b0;
            end
          end else if (last_eol) begin
            state_d = StDone;
          end else begin
            eol_d = 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: ;
    endcase
  end

  always_comb begin
    addr_o = '0;
    dat_o  = '0;
    we_o   = 1'b0;
    sel_o  = '0;
    case (state_q)
      StWrData: begin
        addr_o = ADDR_TXDATA;
        dat_o  = {24'h0, cur_char};
        we_o   = 1'b1;
        sel_o  = 4'b0001;
      end
      StWrCtrl: begin
        addr_o = ADDR_TXCTRL;
        dat_o  = 32'h80;
        we_o   = 1'b1;
        sel_o  = 4'b0001;
      end
      StPollDone, StPollRdy: begin
        addr_o = ADDR_STATUS;
        sel_o  = 4'b1111;
      end
      StClr: begin
        addr_o = ADDR_STATUS;
        we_o   = 1'b1;
        sel_o  = 4'b1111;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign err_o  = err_q;
  assign ovf_o  = ovf_q;
  assign cyc_o  = stb_q;
  assign stb_o  = stb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      val_q    <= '0;
      bcd_q    <= '0;
      conv_q   <= '0;
      dig_q    <= '0;
      in_eol_q <= 1'b0;
      eol_q    <= 1'b0;
      stb_q    <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      bcd_q    <= bcd_d;
      conv_q   <= conv_d;
      dig_q    <= dig_d;
      in_eol_q <= in_eol_d;
      eol_q    <= eol_d;
      stb_q    <= stb_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wb_uart_report_seq.sv
// Scoreboard bench for wb_uart_report_seq: four parameter variants, each with a randomised
// Wishbone slave model and a monitor that checks every UART register access and report end.
module tb_wb_uart_report_seq;

  localparam int NI = 4;
  localparam logic [31:0] AData = 32'h7;
  localparam logic [31:0] ACtrl = 32'h3;
  localparam logic [31:0] AStat = 32'h5;
  localparam int Ato = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_s, start_s, hold_s;
  logic [31:0]   value_s [NI];
  int            err_at [NI];

  logic        busy_w [NI], done_w [NI], err_w [NI], ovf_w [NI];
  logic        we_w [NI], cyc_w [NI], stb_w [NI];
  logic [31:0] addr_w [NI], dato_w [NI];
  logic [3:0]  sel_w [NI];

  byte unsigned exp_ch [NI][$];
  logic [1:0]   exp_dn [NI][$];
  int errors = 0;
  int checks = 0;

  function automatic void chk(input bit ok, input string nm, input longint act,
                              input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endfunction

  function automatic bit all_zero(input int i);
    return !busy_w[i] && !done_w[i] && !err_w[i] && !ovf_w[i] && !we_w[i] && !cyc_w[i] &&
           !stb_w[i] && (addr_w[i] == 32'h0) && (dato_w[i] == 32'h0) && (sel_w[i] == 4'h0);
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int ND  = (gi == 3) ? 4 : 10;
    localparam int SZ  = (gi == 2) ? 0 : 1;
    localparam int EOL = (gi == 1) ? 0 : ((gi == 2) ? 1 : 2);
    localparam int GAP = (gi == 0) ? 1000 : 3;

    logic         ack, berr;
    logic [31:0]  dati;
    int           cnt, lat, ndata, rdcnt, dthr, rthr, len;
    bit           cyc_chk, busy_chk;
    byte unsigned ch;
    logic [1:0]   dn;

    wb_uart_report_seq #(
      .VALUE_W(32), .NUM_DIGITS(ND), .SUPPRESS_ZEROS(SZ), .EOL_MODE(EOL),
      .ADDR_TXDATA(AData), .ADDR_TXCTRL(ACtrl), .ADDR_STATUS(AStat),
      .TX_DONE_BIT(5), .TX_READY_BIT(4), .GAP_CYCLES(GAP), .ACK_TIMEOUT(Ato)
    ) u_dut (
      .clk_i(clk), .rst_i(rst_s[gi]), .start_i(start_s[gi]), .value_i(value_s[gi]),
      .busy_o(busy_w[gi]), .done_o(done_w[gi]), .err_o(err_w[gi]), .ovf_o(ovf_w[gi]),
      .addr_o(addr_w[gi]), .dat_o(dato_w[gi]), .dat_i(dati), .we_o(we_w[gi]),
      .sel_o(sel_w[gi]), .cyc_o(cyc_w[gi]), .stb_o(stb_w[gi]), .ack_i(ack), .err_i(berr)
    );

    // Slave: ack after 1-3 cycles; status done/ready bits appear after a few polls.
    always @(posedge clk) begin
      if (rst_s[gi]) begin
        ack <= 1'b0; berr <= 1'b0; dati <= 32'h0;
        cnt = 0; ndata = 0; lat = 1;
      end else begin
        if (start_s[gi] && !busy_w[gi]) ndata = 0;
        if (ack || berr) begin
          ack <= 1'b0; berr <= 1'b0; cnt = 0;
        end else if (stb_w[gi]) begin
          cnt++;
          if (!hold_s[gi] && cnt >= lat) begin
            lat = $urandom_range(1, 3);
            ack <= 1'b1;
            if (we_w[gi] && addr_w[gi] == AData) begin
              ndata++;
              if (ndata == err_at[gi]) begin ack <= 1'b0; berr <= 1'b1; end
            end
            if (we_w[gi] && addr_w[gi] == ACtrl) begin
              rdcnt = 0;
              dthr  = $urandom_range(0, 2);
              rthr  = dthr + $urandom_range(0, 1);
            end
            if (!we_w[gi] && addr_w[gi] == AStat) begin
              rdcnt++;
              dati <= {26'h0, rdcnt > dthr, rdcnt > rthr, 4'h0};
            end
          end
        end else begin
          cnt = 0;
        end
      end
    end

    always @(negedge clk) begin
      if (rst_s[gi]) begin
        len = 0; cyc_chk = 0; busy_chk = 0;
      end else begin
        if (cyc_chk) begin
          chk(!cyc_w[gi], "cyc_low_after_err", cyc_w[gi], 0);
          cyc_chk = 0;
        end
        if (busy_chk) begin
          chk(!busy_w[gi], "busy_after_done", busy_w[gi], 0);
          busy_chk = 0;
        end
        if (stb_w[gi]) len++;
        else if (len != 0) begin
          if (hold_s[gi]) chk(len == Ato, "stb_timeout_len", len, Ato);
          else chk(len >= 2 && len <= 4, "stb_len", len, 3);
          len = 0;
        end
        if (stb_w[gi] && berr) cyc_chk = 1;
        if (stb_w[gi] && ack && we_w[gi]) begin
          case (addr_w[gi])
            AData: begin
              if (exp_ch[gi].size() == 0) chk(0, "extra_txdata", dato_w[gi], 0);
              else begin
                ch = exp_ch[gi].pop_front();
                chk(dato_w[gi] == {24'h0, ch} && sel_w[gi] == 4'b0001, "txdata",
                    {sel_w[gi], dato_w[gi]}, {4'b0001, 24'h0, ch});
              end
            end
            ACtrl: chk(dato_w[gi] == 32'h80 && sel_w[gi] == 4'b0001, "txctrl",
                       {sel_w[gi], dato_w[gi]}, 36'h1_0000_0080);
            AStat: chk(dato_w[gi] == 32'h0 && sel_w[gi] == 4'b1111, "status_clr",
                       {sel_w[gi], dato_w[gi]}, 36'hF_0000_0000);
            default: chk(0, "bad_write_addr", addr_w[gi], 0);
          endcase
        end
        if (done_w[gi]) begin
          if (exp_dn[gi].size() == 0) chk(0, "extra_done", {err_w[gi], ovf_w[gi]}, 0);
          else begin
            dn = exp_dn[gi].pop_front();
            chk({err_w[gi], ovf_w[gi]} == dn, "done_err_ovf", {err_w[gi], ovf_w[gi]}, dn);
          end
          chk(exp_ch[gi].size() == 0, "chars_missing", exp_ch[gi].size(), 0);
          chk(busy_w[gi], "busy_at_done", busy_w[gi], 1);
          busy_chk = 1;
        end
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] v, input string s, input logic e,
                       input logic o);
    for (int k = 0; k < s.len(); k++) exp_ch[i].push_back(s[k]);
    exp_dn[i].push_back({e, o});
    @(negedge clk);
    start_s[i] = 1'b1;
    value_s[i] = v;
    @(negedge clk);
    start_s[i] = 1'b0;
    chk(busy_w[i], "busy_after_accept", busy_w[i], 1);
  endtask

  task automatic pulse_busy(input int i, input logic [31:0] v);
    @(negedge clk);
    start_s[i] = 1'b1;
    value_s[i] = v;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (!done_w[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_w[i]) chk(0, "done_timeout", n, budget);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_s = '1; start_s = '0; hold_s = '0;
    for (int i = 0; i < NI; i++) begin
      value_s[i] = '0;
      err_at[i]  = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk(all_zero(i), "reset_outputs", i, 0);
    rst_s = '0;

    issue(0, 1234, "1234\r\n", 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    pulse_busy(0, 999);
    wait_done(0, 20000);

    issue(1, 0, "0", 1'b0, 1'b0);
    wait_done(1, 2000);
    issue(1, 42, "42", 1'b0, 1'b0);
    wait_done(1, 2000);
    issue(2, 42, "0000000042\n", 1'b0, 1'b0);
    wait_done(2, 2000);

    issue(3, 12345, "2345\r\n", 1'b0, 1'b1);
    wait_done(3, 2000);
    issue(3, 9999, "9999\r\n", 1'b0, 1'b0);
    wait_done(3, 2000);
    issue(3, 10000, "0\r\n", 1'b0, 1'b1);
    wait_done(3, 2000);
    repeat (5) @(negedge clk);
    chk(ovf_w[3], "ovf_hold", ovf_w[3], 1);

    err_at[0] = 3;
    issue(0, 1234, "12", 1'b1, 1'b0);
    wait_done(0, 20000);
    err_at[0] = 0;
    repeat (5) @(negedge clk);
    chk(err_w[0], "err_hold", err_w[0], 1);

    hold_s[0] = 1'b1;
    issue(0, 5, "", 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    pulse_busy(0, 77);
    wait_done(0, 2000);
    hold_s[0] = 1'b0;

    issue(0, 56, "56\r\n", 1'b0, 1'b0);
    n = 0;
    while (!(stb_w[0] && !we_w[0] && addr_w[0] == AStat) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(stb_w[0] && !we_w[0] && addr_w[0] == AStat, "reach_poll_done", n, 0);
    rst_s[0] = 1'b1;
    @(negedge clk);
    chk(all_zero(0), "reset_mid_poll", 0, 1);
    @(negedge clk);
    rst_s[0] = 1'b0;
    exp_ch[0].delete();
    exp_dn[0].delete();
    issue(0, 907, "907\r\n", 1'b0, 1'b0);
    wait_done(0, 20000);

    repeat (5) @(negedge clk);
    for (int i = 0; i < NI; i++) chk(exp_dn[i].size() == 0, "pending_done", exp_dn[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
